// File: rtl/gpi_debounce.sv
// Debounced general-purpose input block: per-pin 2-flop synchronizer, threshold
// debounce counter, rising-edge sticky interrupt status with mask and W1C clear.
module gpi_debounce #(
  parameter int          NPORT   = 4,
  parameter int          CNT_W   = 16,
  parameter int unsigned DB_INIT = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  input  logic             wr_en,
  input  logic [1:0]       addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  input  logic [NPORT-1:0] inPort,
  output logic             irq
);

  localparam logic [1:0] ADDR_IDR = 2'd0;
  localparam logic [1:0] ADDR_IMR = 2'd1;
  localparam logic [1:0] ADDR_ISR = 2'd2;
  localparam logic [1:0] ADDR_DBR = 2'd3;

  logic [NPORT-1:0] s1;
  logic [NPORT-1:0] s2;
  logic [NPORT-1:0] stable;
  logic [NPORT-1:0] stable_n;
  logic [NPORT-1:0] imr;
  logic [NPORT-1:0] isr;
  logic [NPORT-1:0] isr_n;
  logic [NPORT-1:0] rise;
  logic [NPORT-1:0] clr;
  logic [CNT_W-1:0] dbr;
  logic [CNT_W-1:0] cnt   [NPORT];
  logic [CNT_W-1:0] cnt_n [NPORT];
  logic             wr;

  // Only a slice of wdata is meaningful for any register; the rest is ignored.
  wire unused_wdata = ^wdata;

  assign wr = ce & wr_en;

  always_comb begin
    stable_n = stable;
    for (int i = 0; i < NPORT; i++) begin
      cnt_n[i] = cnt[i];
      if (s2[i] != stable[i]) begin
        if (cnt[i] >= dbr) begin
          stable_n[i] = s2[i];
          cnt_n[i]    = '0;
        end else if (cnt[i] != {CNT_W{1'b1}}) begin
          cnt_n[i] = cnt[i] + CNT_W'(1);
        end
      end else begin
        cnt_n[i] = '0;
      end
    end
  end

  // A set event on the same edge as a W1C clear wins because it is OR-ed in last.
  always_comb begin
    rise  = stable_n & ~stable & imr;
    clr   = (wr && addr == ADDR_ISR) ? wdata[NPORT-1:0] : '0;
    isr_n = (isr & ~clr) | rise;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1     <= '0;
      s2     <= '0;
      stable <= '0;
      imr    <= '0;
      isr    <= '0;
      dbr    <= CNT_W'(DB_INIT);
      for (int i = 0; i < NPORT; i++) cnt[i] <= '0;
    end else begin
      s1     <= inPort;
      s2     <= s1;
      stable <= stable_n;
      isr    <= isr_n;
      cnt    <= cnt_n;
      if (wr && addr == ADDR_IMR) imr <= wdata[NPORT-1:0];
      if (wr && addr == ADDR_DBR) dbr <= wdata[CNT_W-1:0];
    end
  end

  assign irq = |(isr & imr);

  always_comb begin
    rdata = '0;
    if (ce && !wr_en) begin
      case (addr)
        ADDR_IDR: rdata[NPORT-1:0] = stable;
        ADDR_IMR: rdata[NPORT-1:0] = imr;
        ADDR_ISR: rdata[NPORT-1:0] = isr;
        ADDR_DBR: rdata[CNT_W-1:0] = dbr;
        default:  rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_gpi_debounce.sv
// Directed bench for gpi_debounce: latency, glitch rejection, interrupt
// set/mask/W1C behaviour, set-vs-clear priority and asynchronous reset.
module tb_gpi_debounce;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce;
  logic        wr_en;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [3:0]  in_port;
  logic        irq;

  int checks = 0;
  int errors = 0;

  gpi_debounce dut (
    .clk    (clk),
    .reset  (reset),
    .ce     (ce),
    .wr_en  (wr_en),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .inPort (in_port),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    ce = 1'b1; wr_en = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    ce = 1'b0; wr_en = 1'b0; wdata = '0;
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
    ce = 1'b1; wr_en = 1'b0; addr = a;
    #1;
    check(tag, rdata, exp);
    ce = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ce = 1'b0; wr_en = 1'b0; addr = '0; wdata = '0; in_port = '0;
    cyc(2);
    rd_chk("rst_idr", 2'd0, 32'h0);
    rd_chk("rst_dbr", 2'd3, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    reset = 1'b0;
    cyc(1);

    // DBR=0: two-edge latency
    in_port = 4'h5;
    cyc(2);
    rd_chk("lat_k1", 2'd0, 32'h0);
    cyc(1);
    rd_chk("lat_k2", 2'd0, 32'h5);
    addr = 2'd0; #1;
    check("rdata_ce0", rdata, 32'h0);

    // DBR=3: 3-cycle glitch rejected, held level accepted at k+5
    in_port = 4'h0;
    cyc(4);
    rd_chk("idr_low", 2'd0, 32'h0);
    wr(2'd3, 32'h3);
    rd_chk("dbr_rd", 2'd3, 32'h3);
    in_port = 4'h1;
    cyc(3);
    in_port = 4'h0;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      rd_chk("glitch", 2'd0, 32'h0);
    end
    in_port = 4'h1;
    cyc(5);
    rd_chk("db_k4", 2'd0, 32'h0);
    cyc(1);
    rd_chk("db_k5", 2'd0, 32'h1);
    rd_chk("isr_masked", 2'd2, 32'h0);

    // Enabled rising edge sets ISR, W1C clears it
    in_port = 4'h0;
    cyc(8);
    wr(2'd1, 32'h1);
    in_port = 4'h1;
    cyc(8);
    rd_chk("isr_set", 2'd2, 32'h1);
    check("irq_set", {31'h0, irq}, 32'h1);
    wr(2'd2, 32'h1);
    check("irq_clr", {31'h0, irq}, 32'h0);
    rd_chk("isr_clr", 2'd2, 32'h0);

    // Masked pin1 rise does not set ISR
    in_port = 4'h3;
    cyc(8);
    rd_chk("idr_3", 2'd0, 32'h3);
    rd_chk("isr_nomask", 2'd2, 32'h0);
    check("irq_nomask", {31'h0, irq}, 32'h0);

    // Falling edge never sets; IMR clear leaves ISR intact
    wr(2'd1, 32'h2);
    in_port = 4'h1;
    cyc(8);
    rd_chk("idr_fall", 2'd0, 32'h1);
    rd_chk("isr_fall", 2'd2, 32'h0);
    in_port = 4'h3;
    cyc(8);
    rd_chk("isr_p1", 2'd2, 32'h2);
    check("irq_p1", {31'h0, irq}, 32'h1);
    wr(2'd1, 32'h0);
    check("irq_unmask", {31'h0, irq}, 32'h0);
    rd_chk("isr_kept", 2'd2, 32'h2);
    wr(2'd2, 32'hF);
    rd_chk("isr_w1c_all", 2'd2, 32'h0);

    // Set and W1C on the same edge: set wins
    wr(2'd3, 32'h0);
    wr(2'd1, 32'h4);
    in_port = 4'h7;
    cyc(4);
    rd_chk("isr_p2", 2'd2, 32'h4);
    in_port = 4'h3;
    cyc(4);
    rd_chk("isr_sticky", 2'd2, 32'h4);
    rd_chk("idr_p2lo", 2'd0, 32'h3);
    in_port = 4'h7;
    cyc(2);
    wr(2'd2, 32'h4);
    rd_chk("idr_p2hi", 2'd0, 32'h7);
    rd_chk("isr_setwins", 2'd2, 32'h4);
    check("irq_setwins", {31'h0, irq}, 32'h1);

    // Reset mid-debounce
    wr(2'd3, 32'd10);
    in_port = 4'hF;
    cyc(7);
    rd_chk("idr_mid", 2'd0, 32'h7);
    ce = 1'b1; wr_en = 1'b1; addr = 2'd0; wdata = '0;
    #1;
    check("rd_wren", rdata, 32'h0);
    ce = 1'b0; wr_en = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    check("arst_irq", {31'h0, irq}, 32'h0);
    rd_chk("arst_idr", 2'd0, 32'h0);
    rd_chk("arst_imr", 2'd1, 32'h0);
    rd_chk("arst_isr", 2'd2, 32'h0);
    rd_chk("arst_dbr", 2'd3, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Pins held high after reset act as fresh rising edges
    wr(2'd1, 32'hF);
    cyc(3);
    rd_chk("post_idr", 2'd0, 32'hF);
    rd_chk("post_isr", 2'd2, 32'hF);
    check("post_irq", {31'h0, irq}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
